// File: rtl/pio_rq_wr_gen.sv
// PIO write-request to PCIe RQ AXI-Stream converter: builds the 128-bit RQ descriptor,
// shifts the DW-aligned payload up by 4 DW through a carry register, and assigns tags.
module pio_rq_wr_gen #(
  parameter int unsigned USER_WIDTH = 128,
  parameter int unsigned DATA_W     = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  align_valid,
  input  logic                  align_last,
  input  logic [USER_WIDTH-1:0] align_user,
  input  logic [DATA_W-1:0]     align_data,
  output logic                  align_ready,
  output logic                  rq_tvalid,
  output logic                  rq_tlast,
  output logic [255:0]          rq_tdata,
  output logic [7:0]            rq_tkeep,
  output logic [59:0]           rq_tuser,
  input  logic                  rq_tready
);

  typedef enum logic [1:0] {HEAD, BODY, FLUSH} state_t;

  state_t       state;
  logic [127:0] carry;
  logic [7:0]   tag;
  logic         sop;
  logic [10:0]  dw_len_q;
  logic [3:0]   fbe_q;
  logic [3:0]   lbe_q;
  logic [11:0]  out_left;

  logic         load;
  logic         take;
  logic [10:0]  in_len;
  logic [10:0]  in_len_m1;
  logic [10:0]  q_len_m1;
  logic [3:0]   in_type;
  logic [3:0]   in_fbe;
  logic [3:0]   in_lbe;
  logic [61:0]  in_addr;
  logic [11:0]  head_left;
  logic         head_short;
  logic         body_short;
  logic [7:0]   tag_cur;
  logic [127:0] desc;
  logic         unused_user;

  function automatic logic [7:0] keep_of(input logic [11:0] n);
    if (n >= 12'd8) begin
      return 8'hFF;
    end
    return 8'((9'd1 << n[2:0]) - 9'd1);
  endfunction

  assign load        = !rq_tvalid || rq_tready;
  assign align_ready = !rst && load && (state != FLUSH);
  assign take        = align_valid && align_ready;

  assign in_len    = align_user[18:8];
  assign in_type   = align_user[107:104];
  assign in_fbe    = align_user[7:4];
  assign in_lbe    = align_user[3:0];
  assign in_addr   = align_user[95:34];
  assign in_len_m1 = in_len - 11'd1;
  assign q_len_m1  = dw_len_q - 11'd1;
  assign head_left = {1'b0, in_len} + 12'd4;

  // The last input beat fits in the shifted output only if it carries at most 4 payload DW.
  assign head_short = !in_len_m1[2];
  assign body_short = !q_len_m1[2];

  // A packet loaded in the same cycle the previous first beat is taken must see the next tag.
  assign tag_cur = tag + {7'd0, rq_tvalid && rq_tready && sop};

  assign desc = {24'd0, tag_cur, 16'd0, 1'b0, in_type, in_len, in_addr, 2'b00};

  assign unused_user = ^align_user;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HEAD;
      carry     <= '0;
      tag       <= '0;
      sop       <= 1'b0;
      dw_len_q  <= '0;
      fbe_q     <= '0;
      lbe_q     <= '0;
      out_left  <= '0;
      rq_tvalid <= 1'b0;
      rq_tlast  <= 1'b0;
      rq_tdata  <= '0;
      rq_tkeep  <= '0;
      rq_tuser  <= '0;
    end else begin
      if (rq_tvalid && rq_tready && sop) begin
        tag <= tag + 8'd1;
      end
      if (load) begin
        rq_tvalid <= 1'b0;
        rq_tlast  <= 1'b0;
        unique case (state)
          HEAD: begin
            if (take) begin
              rq_tvalid <= 1'b1;
              sop       <= 1'b1;
              rq_tdata  <= {align_data[127:0], desc};
              rq_tkeep  <= keep_of(head_left);
              rq_tuser  <= {52'd0, in_lbe, in_fbe};
              carry     <= align_data[255:128];
              dw_len_q  <= in_len;
              fbe_q     <= in_fbe;
              lbe_q     <= in_lbe;
              out_left  <= head_left - 12'd8;
              if (align_last && head_short) begin
                rq_tlast <= 1'b1;
              end else if (align_last) begin
                state <= FLUSH;
              end else begin
                state <= BODY;
              end
            end
          end
          BODY: begin
            if (take) begin
              rq_tvalid <= 1'b1;
              sop       <= 1'b0;
              rq_tdata  <= {align_data[127:0], carry};
              rq_tkeep  <= keep_of(out_left);
              rq_tuser  <= {52'd0, lbe_q, fbe_q};
              carry     <= align_data[255:128];
              out_left  <= out_left - 12'd8;
              if (align_last) begin
                if (body_short) begin
                  rq_tlast <= 1'b1;
                  state    <= HEAD;
                end else begin
                  state <= FLUSH;
                end
              end
            end
          end
          FLUSH: begin
            rq_tvalid <= 1'b1;
            sop       <= 1'b0;
            rq_tlast  <= 1'b1;
            rq_tdata  <= {128'd0, carry};
            rq_tkeep  <= keep_of(out_left);
            rq_tuser  <= {52'd0, lbe_q, fbe_q};
            out_left  <= out_left - 12'd8;
            state     <= HEAD;
          end
          default: state <= HEAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pio_rq_wr_gen.sv
// Scoreboard bench for pio_rq_wr_gen: the reference model lays out descriptor + payload as one
// DW stream, chops it into 8-DW beats, and a negedge monitor compares every accepted beat.
module tb_pio_rq_wr_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         align_valid;
  logic         align_last;
  logic [127:0] align_user;
  logic [255:0] align_data;
  logic         align_ready;
  logic         rq_tvalid;
  logic         rq_tlast;
  logic [255:0] rq_tdata;
  logic [7:0]   rq_tkeep;
  logic [59:0]  rq_tuser;
  logic         rq_tready = 1'b1;

  typedef struct {
    logic [255:0] data;
    logic [7:0]   keep;
    logic         last;
    logic [59:0]  user;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] payload[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  exp_tag = 8'd0;
  bit          ready_rand = 1'b0;

  pio_rq_wr_gen dut (
    .clk         (clk),
    .rst         (rst),
    .align_valid (align_valid),
    .align_last  (align_last),
    .align_user  (align_user),
    .align_data  (align_data),
    .align_ready (align_ready),
    .rq_tvalid   (rq_tvalid),
    .rq_tlast    (rq_tlast),
    .rq_tdata    (rq_tdata),
    .rq_tkeep    (rq_tkeep),
    .rq_tuser    (rq_tuser),
    .rq_tready   (rq_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference model: whole packet as a DW stream, 8 DW per output beat.
  task automatic push_expected(input int dw, input logic [3:0] typ, input logic [63:0] addr,
                               input logic [3:0] fbe, input logic [3:0] lbe,
                               input logic [7:0] tag);
    logic [31:0] s[$];
    int nb;
    beat_t e;
    s.push_back({addr[31:2], 2'b00});
    s.push_back(addr[63:32]);
    s.push_back({17'd0, typ, 11'(dw)});
    s.push_back({24'd0, tag});
    foreach (payload[k]) s.push_back(payload[k]);
    nb = (s.size() + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      e.keep = '0;
      for (int i = 0; i < 8; i++) begin
        if (b * 8 + i < s.size()) begin
          e.data[i*32 +: 32] = s[b*8+i];
          e.keep[i] = 1'b1;
        end
      end
      e.last = (b == nb - 1);
      e.user = {52'd0, lbe, fbe};
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_tvalid", 256'(rq_tvalid), 256'(1'b0));
    chk("rst_tlast", 256'(rq_tlast), 256'(1'b0));
    chk("rst_tdata", rq_tdata, 256'd0);
    chk("rst_tkeep", 256'(rq_tkeep), 256'd0);
    chk("rst_tuser", 256'(rq_tuser), 256'd0);
    chk("rst_align_ready", 256'(align_ready), 256'(1'b0));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    align_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    exp_tag = 8'd0;
    @(posedge clk);
    #1;
  endtask

  // abort_beat >= 0 asserts rst while that input beat is presented.
  task automatic send_pkt(input int dw, input logic [3:0] typ, input logic [63:0] addr,
                          input logic [3:0] fbe, input logic [3:0] lbe, input int abort_beat);
    int nin;
    int cnt;
    logic [127:0] u;
    payload.delete();
    for (int i = 0; i < dw; i++) payload.push_back($urandom);
    push_expected(dw, typ, addr, fbe, lbe, exp_tag);
    exp_tag++;
    nin = (dw + 7) / 8;
    for (int j = 0; j < nin; j++) begin
      u = {$urandom, $urandom, $urandom, $urandom};
      if (j == 0) begin
        u[107:104] = typ;
        u[95:32]   = addr;
        u[18:8]    = 11'(dw);
        u[7:4]     = fbe;
        u[3:0]     = lbe;
      end
      for (int i = 0; i < 8; i++) begin
        align_data[i*32 +: 32] = (j * 8 + i < dw) ? payload[j*8+i] : $urandom;
      end
      align_user  = u;
      align_last  = (j == nin - 1);
      align_valid = 1'b1;
      if (j == abort_beat) begin
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        align_valid = 1'b0;
        exp_tag = 8'd0;
        return;
      end
      cnt = 0;
      forever begin
        @(negedge clk);
        #1;
        if (align_ready) break;
        cnt++;
        if (cnt > 2000) break;
      end
      if (cnt > 2000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL input_accept_timeout: got no align_ready, expected ready within 2000 cycles");
        align_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    align_valid = 1'b0;
    // One extra output beat means the DUT must be draining the carry right now.
    if ((dw + 11) / 8 > nin) chk("flush_stall", 256'(align_ready), 256'(1'b0));
  endtask

  task automatic wait_drain();
    int cnt = 0;
    while (exp_q.size() > 0 && cnt < 5000) begin
      @(posedge clk);
      cnt++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: ready for the coming edge is chosen here, so a handshake is known before it occurs.
  bit    stalled = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    beat_t e;
    logic [255:0] mask;
    rq_tready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_data", rq_tdata, held.data);
        chk("stall_ctrl", 256'({rq_tvalid, rq_tkeep, rq_tlast, rq_tuser}),
            256'({1'b1, held.keep, held.last, held.user}));
      end
      if (rq_tvalid && rq_tready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got tdata %h, expected no beat", rq_tdata);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 8; i++) mask[i*32 +: 32] = {32{e.keep[i]}};
          chk("beat_data", rq_tdata & mask, e.data);
          chk("beat_keep_last_user", 256'({rq_tkeep, rq_tlast, rq_tuser}),
              256'({e.keep, e.last, e.user}));
        end
      end else if (rq_tvalid) begin
        stalled   = 1'b1;
        held.data = rq_tdata;
        held.keep = rq_tkeep;
        held.last = rq_tlast;
        held.user = rq_tuser;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int dw;
    rst         = 1'b1;
    align_valid = 1'b0;
    align_last  = 1'b0;
    align_user  = '0;
    align_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases with the sink always ready.
    send_pkt(4, 4'h1, 64'h1000, 4'hF, 4'hF, -1);
    send_pkt(5, 4'h1, 64'h0000_0001_2345_6780, 4'hF, 4'h1, -1);
    wait_drain();
    send_pkt(12, 4'h1, 64'hABCD_0000_0000_0040, 4'hF, 4'hF, -1);
    send_pkt(13, 4'h1, 64'h0000_0000_8000_0100, 4'h3, 4'hC, -1);
    wait_drain();

    // Maximum length with a randomly stalling sink.
    ready_rand = 1'b1;
    send_pkt(1024, 4'h1, 64'hFFFF_FFFF_FFFF_F000, 4'hF, 4'hF, -1);
    wait_drain();

    // Tag wrap over 257 single-beat packets.
    apply_reset();
    for (int p = 0; p < 257; p++) begin
      send_pkt(int'($urandom_range(1, 4)), 4'h1, {$urandom, $urandom}, 4'($urandom),
               4'($urandom), -1);
    end
    wait_drain();

    // Reset on the third input beat, then a clean packet must restart at tag 0.
    send_pkt(64, 4'h1, 64'h2000, 4'hF, 4'hF, 2);
    send_pkt(4, 4'h1, 64'h3000, 4'hF, 4'hF, -1);
    wait_drain();

    // Random mix of lengths, addresses, byte enables and types.
    for (int p = 0; p < 60; p++) begin
      dw = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 40))
                                       : int'($urandom_range(1, 300));
      send_pkt(dw, 4'($urandom), {$urandom, $urandom}, 4'($urandom), 4'($urandom), -1);
    end
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_rq_wr_gen.md
# pio_rq_wr_gen

Converts the DW-aligned PIO write-request stream into Requester Request (RQ) AXI-Stream beats for the PCIe hard IP. Sits directly downstream of the PIO DW-alignment stage: consumes its `align_*` stream and builds the 128-bit RQ descriptor from `align_user`. It places the descriptor in the low half of the first output beat and shifts the payload up by 4 DW across beats, with a 4-DW carry register. It also generates per-packet tags and `rq_tkeep`.

## Interface
- `USER_WIDTH`, 128: width of `align_user`; bits above 127 are ignored.
- `DATA_W`, 256: payload width, 8 DW per beat. Only 256 is supported.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `align_valid`  in  1  input beat valid.
- `align_last`  in  1  last input beat of a packet.
- `align_user`  in  USER_WIDTH  header, valid on the first beat: [107:104] req type, [95:32] DW-aligned address, [18:8] DW length (1..1024), [7:4] first BE, [3:0] last BE.
- `align_data`  in  DATA_W  payload; DW0 at [31:0].
- `align_ready`  out  1  input accepted when `align_valid & align_ready`.
- `rq_tvalid`  out  1  output beat valid.
- `rq_tlast`  out  1  last output beat.
- `rq_tdata`  out  256  descriptor and payload.
- `rq_tkeep`  out  8  per-DW valid.
- `rq_tuser`  out  60  [3:0] first BE, [7:4] last BE, all other bits 0.
- `rq_tready`  in  1  sink ready.

## Operation
- **Descriptor fields** (first beat only), by `rq_tdata` bit:
  - [1:0] = 0
  - [63:2] = addr[63:2]
  - [74:64] = dw_len
  - [78:75] = req type
  - [79] = 0
  - [95:80] = 0
  - [103:96] = tag
  - [127:104] = 0
- **Tag:** 8-bit counter, reset value 0. Used for the current packet and incremented when the first beat is accepted by the sink. Wraps 255→0.
- **Header latch:** dw_len, first BE and last BE are captured on the first input handshake and held until the packet's last output beat.
- **FSM states:** HEAD, BODY, FLUSH.
  - HEAD: accepts the first input beat. Output = {in[127:0], descriptor}; carry ← in[255:128].
    - If `align_last` and (dw_len−1)&7 < 4: → HEAD, beat is last.
    - Else if `align_last`: → FLUSH.
    - Else: → BODY.
  - BODY: each accepted input beat outputs {in[127:0], carry}; carry ← in[255:128].
    - On `align_last`: → FLUSH if (dw_len−1)&7 ≥ 4, else → HEAD with this beat last.
  - FLUSH: no input is consumed (`align_ready` = 0). Output = {128'd0, carry}, last. → HEAD.
- **Keep:** counter `out_left` = dw_len+4 at HEAD; it decreases by 8 per output beat. `rq_tkeep` = 8'hFF if out_left ≥ 8, else (1<<out_left)−1.
- **Upstream contract:** `align_last` must agree with dw_len. This is not checked; a mismatch gives undefined tkeep.
- **Request type:** only memory writes (type 4'h1) are supported. The type field is passed through unchecked.
- **Reset:** reset mid-packet discards the partial packet, clears the carry, and sets the FSM to HEAD and the tag to 0. The sink sees `rq_tvalid` = 0 with no `rq_tlast`.

## Timing
- Outputs are registered, one output register stage; latency is 1 cycle from input handshake to `rq_tvalid`.
- Output registers load when `!rq_tvalid | rq_tready`.
- `align_ready` = (`!rq_tvalid | rq_tready`) & (state ≠ FLUSH). This is combinational from `rq_tready`.
- FLUSH inserts exactly one extra output beat and stalls input for one load slot.
- Full throughput: 1 beat/cycle with `rq_tready` held high, plus one bubble on input per flushed packet.
- `rq_tvalid` stays high and `rq_tdata`/`rq_tkeep`/`rq_tuser`/`rq_tlast` stay stable while `rq_tready` = 0.
- Back-to-back packets: a HEAD input beat may be accepted in the same cycle the previous packet's last beat leaves.
- Reset values: `rq_tvalid` 0, `rq_tlast` 0, `rq_tdata` 0, `rq_tkeep` 0, `rq_tuser` 0, `align_ready` 0 while `rst` is high.

## Test plan
- **dw_len=4, addr 0x1000, one input beat:**
  - One output beat, last, keep 8'hFF.
  - tdata[63:0] = 0x1000, [74:64] = 4, [78:75] = 1, tag 0.
  - tdata[255:128] = input DW0–3.
- **dw_len=5, first BE F, last BE 1:**
  - Two output beats: beat 1 keep FF; beat 2 keep 8'h01 with DW4 at [31:0], last.
  - `align_ready` low for one slot.
  - tuser[7:0] = 8'h1F on beat 1.
- **dw_len=12, then dw_len=13, back-to-back:**
  - 12 → 2 beats (FF, FF), no flush.
  - 13 → 3 beats (FF, FF, 01); tags 0 then 1.
- **dw_len=1024, `rq_tready` toggling randomly every cycle:**
  - 129 output beats, with payload identical to the input shifted by 4 DW.
  - Data held stable while stalled; final keep 8'h0F.
- **Tag wrap:** 257 single-beat packets → tags 0..255 then 0.
- **Reset mid-packet:** assert `rst` on the 3rd beat of a dw_len=64 packet.
  - Outputs return to reset values next cycle.
  - A following dw_len=4 packet gets tag 0 and a correct descriptor.
